// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchronizer, sample-qualified debouncer and
// registered rise/fall pulse generator for asynchronous button/switch inputs.
module input_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  logic [CHANNELS-1:0] level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  logic [CHANNELS-1:0] synced, differ, accept;
  always_comb begin
    sync_d[0] = raw_in;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    synced = sync_q[SYNC_STAGES-1];
    differ = synced ^ level_q;
    accept = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      accept[c] = sample_en && differ[c] && cnt_q[c] == CNT_MAX;
      // a matching sample or an acceptance restarts the run; idle samples hold it
      cnt_d[c]  = !sample_en ? cnt_q[c] : (!differ[c] || accept[c]) ? '0 : cnt_q[c] + CW'(1);
    end
    level_d = level_q ^ accept;
    rise_d  = accept & ~level_q;
    fall_d  = accept & level_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '{default: '0};
      cnt_q   <= '{default: '0};
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: randomized and directed checks of input_conditioner
// against a sample-history reference model, default and 1-channel/1-cycle builds.
module tb_input_conditioner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_en = 1'b1;
  logic [3:0] raw_in = '0;
  logic [0:0] raw1 = '0;
  logic [3:0] level_out, rise_pulse, fall_pulse;
  logic [0:0] level1, rise1, fall1;
  int         vec = 0;
  int         miss = 0;

  input_conditioner dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .raw_in(raw_in),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
  );
  input_conditioner #(.CHANNELS(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .sample_en(sample_en), .raw_in(raw1),
    .level_out(level1), .rise_pulse(rise1), .fall_pulse(fall1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a level flips once the last 4 qualifying synced samples all
  // disagree with it; synced is simply raw_in as it was two clocks ago.
  logic [3:0] mh [2];
  logic [3:0] ms [4];
  logic [3:0] ml, mr, mf, s, nl;
  logic       mh1 [2];
  logic       ml1, mr1, mf1, nl1;
  bit         acc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mh = '{default: '0}; ms = '{default: '0};
      ml = '0; mr = '0; mf = '0;
      mh1 = '{default: 1'b0}; ml1 = 1'b0; mr1 = 1'b0; mf1 = 1'b0;
    end else begin
      s  = mh[1];
      nl = ml;
      if (sample_en) begin
        for (int k = 3; k > 0; k--) ms[k] = ms[k-1];
        ms[0] = s;
        for (int c = 0; c < 4; c++) begin
          acc = 1'b1;
          for (int k = 0; k < 4; k++) if (ms[k][c] == ml[c]) acc = 1'b0;
          if (acc) nl[c] = ~ml[c];
        end
      end
      mr = nl & ~ml; mf = ~nl & ml; ml = nl;
      mh[1] = mh[0]; mh[0] = raw_in;
      nl1 = sample_en ? mh1[1] : ml1;
      mr1 = nl1 & ~ml1; mf1 = ~nl1 & ml1; ml1 = nl1;
      mh1[1] = mh1[0]; mh1[0] = raw1[0];
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("level", level_out, ml);
      chk("rise", rise_pulse, mr);
      chk("fall", fall_pulse, mf);
      chk("rise_fall_excl", rise_pulse & fall_pulse, 0);
      chk("u1_level", level1, ml1);
      chk("u1_rise", rise1, mr1);
      chk("u1_fall", fall1, mf1);
    end
  end

  initial begin
    #3;
    chk("reset_level", level_out, 0);
    chk("reset_pulses", {rise_pulse, fall_pulse}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    raw_in[0] = 1'b1; raw1 = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      if (e == 2) chk("u1_level_e2", level1, 0);
      if (e == 3) chk("u1_level_e3", {level1, rise1}, 2'b11);
      if (e == 4) chk("u1_rise_e4", rise1, 0);
      if (e == 5) chk("ch0_level_e5", level_out, 4'b0000);
      if (e == 6) chk("ch0_rise_e6", {level_out, rise_pulse}, 8'b0001_0001);
      if (e == 7) chk("ch0_rise_e7", {level_out, rise_pulse}, 8'b0001_0000);
    end
    @(negedge clk);
    raw_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    raw_in[1] = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_level", level_out, 4'b0001);
    raw_in[1] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      if (e == 5) chk("ch1_level_e5", level_out, 4'b0001);
      if (e == 6) chk("ch1_rise_e6", {level_out, rise_pulse}, 8'b0011_0010);
    end
    @(negedge clk);
    raw_in[2] = 1'b1;
    repeat (8) @(negedge clk);
    chk("ch2_high", level_out, 4'b0111);
    raw_in[2] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      if (e == 5) chk("ch2_fall_e5", {level_out, fall_pulse}, 8'b0111_0000);
      if (e == 6) chk("ch2_fall_e6", {level_out, fall_pulse}, 8'b0011_0100);
      if (e == 7) chk("ch2_fall_e7", fall_pulse, 0);
    end
    @(negedge clk);
    raw_in[3] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      sample_en = (k % 4 == 0);
      @(posedge clk); #1;
      if (k == 15) chk("ch3_level_e15", level_out, 4'b0011);
      if (k == 16) chk("ch3_rise_e16", {level_out, rise_pulse}, 8'b1011_1000);
      if (k == 19) chk("ch3_hold_e19", {level_out, rise_pulse}, 8'b1011_0000);
      @(negedge clk);
    end
    sample_en = 1'b1;
    raw_in = 4'b1111;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", {level_out, rise_pulse, fall_pulse, level1}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      if (e == 5) chk("rel_e5", {level_out, rise_pulse}, 8'b0000_0000);
      if (e == 6) chk("rel_e6", {level_out, rise_pulse}, 8'b1111_1111);
      if (e == 7) chk("rel_e7", {level_out, rise_pulse}, 8'b1111_0000);
    end
    @(negedge clk);
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 4; c++) if ($urandom_range(0, 7) == 0) raw_in[c] = ~raw_in[c];
      if ($urandom_range(0, 3) == 0) raw1 = ~raw1;
      sample_en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL provide parameter CHANNELS, default 4, number of independent input channels (1..32).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, synchronizer flop depth per channel (>=2).
REQ-003 SHALL provide parameter DEBOUNCE_CYCLES, default 4, consecutive qualifying samples required to accept a new level (>=1).
REQ-004 SHALL provide port clk  input  1  single clock, all state rising-edge triggered.
REQ-005 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL provide port sample_en  input  1  sample qualifier; debounce logic advances only on cycles where it is 1; tie high for per-clock sampling.
REQ-007 SHALL provide port raw_in  input  CHANNELS  asynchronous raw inputs (buttons/switches).
REQ-008 SHALL provide port level_out  output  CHANNELS  debounced level, registered.
REQ-009 SHALL provide port rise_pulse  output  CHANNELS  one-cycle pulse on accepted 0->1, registered.
REQ-010 SHALL provide port fall_pulse  output  CHANNELS  one-cycle pulse on accepted 1->0, registered.

Function
REQ-011 Each channel SHALL be fully independent; no channel's state affects another.
REQ-012 Each channel SHALL pass raw_in[i] through SYNC_STAGES flops every clk, regardless of sample_en; synced[i] is the last stage.
REQ-013 Each channel SHALL hold a counter of width $clog2(DEBOUNCE_CYCLES+1); counter never exceeds DEBOUNCE_CYCLES-1.
REQ-014 On a clk edge with sample_en=1 and synced[i]==level_out[i], counter SHALL clear to 0.
REQ-015 On a clk edge with sample_en=1, synced[i]!=level_out[i] and counter<DEBOUNCE_CYCLES-1, counter SHALL increment by 1.
REQ-016 On a clk edge with sample_en=1, synced[i]!=level_out[i] and counter==DEBOUNCE_CYCLES-1, level_out[i] SHALL take synced[i] and counter SHALL clear to 0.
REQ-017 On a clk edge with sample_en=0, counter and level_out SHALL hold.
REQ-018 rise_pulse[i] SHALL be 1 for exactly the one cycle following the edge where level_out[i] goes 0->1, else 0; fall_pulse[i] likewise for 1->0.
REQ-019 rise_pulse[i] and fall_pulse[i] SHALL never be 1 simultaneously.
REQ-020 Latency with sample_en=1: raw change stable from before edge 1 SHALL appear on level_out at edge SYNC_STAGES+DEBOUNCE_CYCLES (default: edge 6).
REQ-021 A synced glitch lasting fewer than DEBOUNCE_CYCLES qualifying samples SHALL not change level_out and SHALL leave counter at 0 once synced returns to level_out.
REQ-022 DEBOUNCE_CYCLES=1 SHALL accept a new level on the first qualifying sample (synchronizer only).
REQ-023 Channels changing on the same edge SHALL each produce their own pulse on that same cycle.

Reset
REQ-024 While rst=1, all sync flops, counters, level_out, rise_pulse and fall_pulse SHALL be 0, asynchronously, independent of clk.
REQ-025 Reset asserted mid-debounce SHALL discard partial count; after release, a raw_in held at 1 SHALL be treated as a new rising input (full latency, rise_pulse issued).
REQ-026 First edge after rst deassertion SHALL behave as a normal operating edge; no pulses SHALL be generated by reset release itself.

Verification
REQ-027 Defaults, sample_en=1, raw_in[0] 0->1 held -> level_out[0]=1 at edge 6, rise_pulse[0]=1 for exactly one cycle, other channels stay 0.
REQ-028 Defaults, raw_in[1] pulses high for 3 clocks then low -> level_out[1] stays 0, no pulses, counter back to 0.
REQ-029 Defaults, level_out[2]=1, raw_in[2] 1->0 held -> fall_pulse[2] one cycle, level_out[2]=0 at edge 6.
REQ-030 sample_en=1 every 4th clk, raw_in[3] 0->1 held -> level_out[3] rises on the 4th qualifying sample after sync, holds between samples.
REQ-031 raw_in=4'b1111 held, rst pulsed after edge 4 -> all outputs 0 immediately; after release, level_out=4'b1111 at edge 6 post-release with rise_pulse=4'b1111 for one cycle.
REQ-032 CHANNELS=1, DEBOUNCE_CYCLES=1, raw_in 0->1 -> level_out=1 at edge 3, rise_pulse one cycle.
